// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   - Bypass select encodings driven on fwd_sel / used by fwd_compare.
//   - FSM state type (RUN, MC_BUSY).
//   - Helper deciding whether a pipeline slot really writes a register.
package hazard_forward_ctrl_pkg;

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef enum logic [0:0] {
    StRun    = 1'b0,
    StMcBusy = 1'b1
  } state_e;

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic slot_writes(input logic valid, input logic regwrite,
                                       input logic rd_nonzero);
    return valid & regwrite & rd_nonzero;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage request and hazard/bypass response bundle.
//   master: drives the ID-stage instruction fields, observes the controls.
//   slave : the controller; consumes ID fields, drives fwd_sel, fwd_store,
//           stall, bubble and ex_busy.
interface hazard_forward_ctrl_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
);
  logic                        id_valid;
  logic                        id_flush;
  logic [NUM_SRC*REG_AW-1:0]   id_src;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [REG_AW-1:0]           id_rd;
  logic                        id_regwrite;
  logic                        id_memtoreg;
  logic                        id_memwrite;
  logic                        id_multicycle;
  logic [2*NUM_SRC-1:0]        fwd_sel;
  logic                        fwd_store;
  logic                        stall;
  logic                        bubble;
  logic                        ex_busy;

  modport master (
    output id_valid, id_flush, id_src, id_src_used, id_rd,
           id_regwrite, id_memtoreg, id_memwrite, id_multicycle,
    input  fwd_sel, fwd_store, stall, bubble, ex_busy
  );

  modport slave (
    input  id_valid, id_flush, id_src, id_src_used, id_rd,
           id_regwrite, id_memtoreg, id_memwrite, id_multicycle,
    output fwd_sel, fwd_store, stall, bubble, ex_busy
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_compare.sv
// Per-source bypass select for one EX operand.
//   src_i    : source register tag of the EX operand
//   used_i   : operand is actually read (and EX slot valid)
//   mem_rd_i / mem_wr_i : MEM slot destination and "really writes"
//   wb_rd_i  / wb_wr_i  : WB slot destination and "really writes"
//   sel_o    : FwdMem, FwdWb or FwdReg; MEM is younger so it wins.
module hazard_forward_ctrl_fwd_compare
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              used_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_wr_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FwdReg;
    if (used_i) begin
      if (mem_wr_i && (src_i == mem_rd_i)) begin
        sel_o = FwdMem;
      end else if (wb_wr_i && (src_i == wb_rd_i)) begin
        sel_o = FwdWb;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline.
// Tracks its own EX/MEM/WB tag slots fed from ID and produces:
//   fwd_sel   : per EX source bypass select (2 bits per source)
//   fwd_store : MEM store data taken from the WB load result
//   stall     : hold PC and IF/ID
//   bubble    : insert NOP into ID/EX
//   ex_busy   : a multi-cycle op is occupying EX
// Ports: clk, rst_n (async active-low), bus (slave modport of hazard_forward_ctrl_if).
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_forward_ctrl_if.slave bus
);

  localparam int unsigned SrcW     = NUM_SRC * REG_AW;
  localparam int unsigned StoreIdx = (NUM_SRC > 1) ? 1 : 0;
  localparam int unsigned CntW     = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MC_LATENCY - 1);
  localparam logic            McStalls = (MC_LATENCY > 1);

  typedef struct packed {
    logic               valid;
    logic [REG_AW-1:0]  rd;
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic [SrcW-1:0]    src;
    logic [NUM_SRC-1:0] src_used;
    logic [REG_AW-1:0]  store;
  } ex_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic [REG_AW-1:0] store;
  } mem_slot_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memtoreg;
  } wb_slot_t;

  ex_slot_t  ex_q, ex_d, id_slot;
  mem_slot_t mem_q, mem_d;
  wb_slot_t  wb_q, wb_d;
  state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic mem_wr, wb_wr, luse_hit, luse;
  logic [2*NUM_SRC-1:0] fwd_sel;
  logic stall, bubble, ex_busy;

  // Squashed or empty ID entries enter EX as all-zero bubbles.
  always_comb begin
    id_slot = '0;
    if (bus.id_valid && !bus.id_flush) begin
      id_slot.valid    = 1'b1;
      id_slot.rd       = bus.id_rd;
      id_slot.regwrite = bus.id_regwrite;
      id_slot.memtoreg = bus.id_memtoreg;
      id_slot.memwrite = bus.id_memwrite;
      id_slot.src      = bus.id_src;
      id_slot.src_used = bus.id_src_used;
      id_slot.store    = bus.id_src[StoreIdx*REG_AW +: REG_AW];
    end
  end

  assign mem_wr = slot_writes(mem_q.valid, mem_q.regwrite, mem_q.rd != '0);
  assign wb_wr  = slot_writes(wb_q.valid, wb_q.regwrite, wb_q.rd != '0);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    hazard_forward_ctrl_fwd_compare #(
      .REG_AW (REG_AW)
    ) u_cmp (
      .src_i    (ex_q.src[i*REG_AW +: REG_AW]),
      .used_i   (ex_q.valid & ex_q.src_used[i]),
      .mem_rd_i (mem_q.rd),
      .mem_wr_i (mem_wr),
      .wb_rd_i  (wb_q.rd),
      .wb_wr_i  (wb_wr),
      .sel_o    (fwd_sel[2*i +: 2])
    );
  end

  always_comb begin
    luse_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] && (bus.id_src[i*REG_AW +: REG_AW] == ex_q.rd)) begin
        luse_hit = 1'b1;
      end
    end
  end

  assign luse = bus.id_valid & ~bus.id_flush & ex_q.valid & ex_q.memtoreg &
                (ex_q.rd != '0) & luse_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = ex_q;
    mem_d   = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite,
                memtoreg: ex_q.memtoreg, memwrite: ex_q.memwrite, store: ex_q.store};
    wb_d    = '{valid: mem_q.valid, rd: mem_q.rd, regwrite: mem_q.regwrite,
                memtoreg: mem_q.memtoreg};
    stall   = 1'b0;
    bubble  = 1'b0;
    ex_busy = 1'b0;
    unique case (state_q)
      StRun: begin
        stall  = luse;
        bubble = luse;
        if (luse) begin
          ex_d = '0;
        end else begin
          ex_d = id_slot;
          if (id_slot.valid && bus.id_multicycle && McStalls) begin
            state_d = StMcBusy;
            cnt_d   = CntLoad;
          end
        end
      end
      StMcBusy: begin
        stall   = 1'b1;
        ex_busy = 1'b1;
        mem_d   = '0;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.fwd_sel   = fwd_sel;
  assign bus.fwd_store = mem_q.valid & mem_q.memwrite & wb_q.memtoreg & wb_wr &
                         (mem_q.store == wb_q.rd);
  assign bus.stall     = stall;
  assign bus.bubble    = bubble;
  assign bus.ex_busy   = ex_busy;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench for hazard_forward_ctrl (REG_AW=5, NUM_SRC=2, MC_LATENCY=4).
module tb_hazard_forward_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_forward_ctrl_if #(.REG_AW(5), .NUM_SRC(2)) bus ();

  hazard_forward_ctrl #(
    .REG_AW     (5),
    .NUM_SRC    (2),
    .MC_LATENCY (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic id_set(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd, input logic rw,
                        input logic mtr, input logic mw, input logic mc);
    bus.id_valid      = v;
    bus.id_src        = {s1, s0};
    bus.id_src_used   = used;
    bus.id_rd         = rd;
    bus.id_regwrite   = rw;
    bus.id_memtoreg   = mtr;
    bus.id_memwrite   = mw;
    bus.id_multicycle = mc;
  endtask

  task automatic id_idle();
    id_set(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.id_flush = 1'b0;
  endtask

  task automatic drain();
    id_idle();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_idle();
    #2;
    checks++;
    if (bus.fwd_sel !== 4'b0000 || bus.fwd_store !== 1'b0) begin
      errors++;
      $display("FAIL reset_fwd: fwd_sel=%b fwd_store=%b expected 0000/0", bus.fwd_sel,
               bus.fwd_store);
    end
    checks++;
    if (bus.stall !== 1'b0 || bus.bubble !== 1'b0 || bus.ex_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: stall=%b bubble=%b ex_busy=%b expected 0/0/0", bus.stall,
               bus.bubble, bus.ex_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_mem_wb();
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // add $3
    tick();
    id_set(1'b1, 5'd3, 5'd4, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);  // sub $6,$3,$4
    sample();
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_no_stall: stall=%b expected 0", bus.stall);
    end
    tick();
    id_set(1'b1, 5'd3, 5'd5, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);  // and $7,$3,$5
    sample();
    checks++;
    if (bus.fwd_sel !== 4'b0010) begin
      errors++;
      $display("FAIL fwd_mem: fwd_sel=%b expected 0010", bus.fwd_sel);
    end
    tick();
    id_idle();
    sample();
    checks++;
    if (bus.fwd_sel !== 4'b0001) begin
      errors++;
      $display("FAIL fwd_wb: fwd_sel=%b expected 0001", bus.fwd_sel);
    end
    tick();
    // Two writers of $3 in MEM and WB: the younger (MEM) must win on rt.
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    id_set(1'b1, 5'd8, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    id_idle();
    sample();
    checks++;
    if (bus.fwd_sel !== 4'b1000) begin
      errors++;
      $display("FAIL fwd_priority: fwd_sel=%b expected 1000", bus.fwd_sel);
    end
    drain();
  endtask

  task automatic test_load_use();
    id_set(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $5
    tick();
    id_set(1'b1, 5'd2, 5'd5, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);  // add $8,$2,$5
    sample();
    checks++;
    if (bus.stall !== 1'b1 || bus.bubble !== 1'b1) begin
      errors++;
      $display("FAIL luse_on: stall=%b bubble=%b expected 1/1", bus.stall, bus.bubble);
    end
    tick();
    sample();
    checks++;
    if (bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
      errors++;
      $display("FAIL luse_once: stall=%b bubble=%b expected 0/0", bus.stall, bus.bubble);
    end
    tick();
    id_idle();
    sample();
    checks++;
    if (bus.fwd_sel !== 4'b0100) begin
      errors++;
      $display("FAIL luse_fwd_wb: fwd_sel=%b expected 0100", bus.fwd_sel);
    end
    drain();
  endtask

  task automatic test_store_fwd();
    id_set(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $7
    tick();
    id_set(1'b1, 5'd2, 5'd7, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);  // sw $7,0($2)
    sample();
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL sw_no_stall: stall=%b expected 0", bus.stall);
    end
    tick();
    id_idle();
    tick();
    sample();
    checks++;
    if (bus.fwd_store !== 1'b1) begin
      errors++;
      $display("FAIL store_fwd: fwd_store=%b expected 1", bus.fwd_store);
    end
    id_set(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $0
    tick();
    id_set(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);  // sw $0,0($0)
    tick();
    id_idle();
    sample();
    checks++;
    if (bus.fwd_sel !== 4'b0000) begin
      errors++;
      $display("FAIL r0_no_fwd: fwd_sel=%b expected 0000", bus.fwd_sel);
    end
    tick();
    sample();
    checks++;
    if (bus.fwd_store !== 1'b0) begin
      errors++;
      $display("FAIL r0_no_store_fwd: fwd_store=%b expected 0", bus.fwd_store);
    end
    drain();
  endtask

  task automatic test_multicycle();
    logic [3:0] exp_fwd [3];
    exp_fwd[0] = 4'b0010;  // add $9 in MEM
    exp_fwd[1] = 4'b0001;  // add $9 in WB, bubble in MEM
    exp_fwd[2] = 4'b0000;  // bubbles in MEM and WB
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);  // add $9
    tick();
    id_set(1'b1, 5'd9, 5'd10, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // mult $9,$10
    tick();
    id_set(1'b1, 5'd11, 5'd12, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // second mult
    for (int c = 0; c < 3; c++) begin
      sample();
      checks++;
      if (bus.ex_busy !== 1'b1 || bus.stall !== 1'b1 || bus.bubble !== 1'b0) begin
        errors++;
        $display("FAIL mc_busy_c%0d: ex_busy=%b stall=%b bubble=%b expected 1/1/0", c + 1,
                 bus.ex_busy, bus.stall, bus.bubble);
      end
      checks++;
      if (bus.fwd_sel !== exp_fwd[c]) begin
        errors++;
        $display("FAIL mc_fwd_c%0d: fwd_sel=%b expected %b", c + 1, bus.fwd_sel, exp_fwd[c]);
      end
      tick();
    end
    sample();
    checks++;
    if (bus.ex_busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL mc_release: ex_busy=%b stall=%b expected 0/0", bus.ex_busy, bus.stall);
    end
    tick();
    id_idle();
    sample();
    checks++;
    if (bus.ex_busy !== 1'b1) begin
      errors++;
      $display("FAIL mc_back_to_back: ex_busy=%b expected 1", bus.ex_busy);
    end
    drain();
  endtask

  task automatic test_flush();
    id_set(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $5
    tick();
    id_set(1'b1, 5'd5, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.id_flush = 1'b1;
    sample();
    checks++;
    if (bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
      errors++;
      $display("FAIL flush_masks_luse: stall=%b bubble=%b expected 0/0", bus.stall, bus.bubble);
    end
    tick();
    bus.id_flush = 1'b0;
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // mult
    tick();
    id_set(1'b1, 5'd3, 5'd4, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.id_flush = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      checks++;
      if (bus.ex_busy !== (c < 3)) begin
        errors++;
        $display("FAIL flush_mc_c%0d: ex_busy=%b expected %b", c + 1, bus.ex_busy, (c < 3));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid_busy();
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // mult
    tick();
    id_idle();
    sample();
    checks++;
    if (bus.ex_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: ex_busy=%b expected 1", bus.ex_busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ex_busy !== 1'b0 || bus.stall !== 1'b0 || bus.bubble !== 1'b0 ||
        bus.fwd_sel !== 4'b0000 || bus.fwd_store !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: ex_busy=%b stall=%b bubble=%b fwd_sel=%b fwd_store=%b exp 0",
               bus.ex_busy, bus.stall, bus.bubble, bus.fwd_sel, bus.fwd_store);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.ex_busy !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: ex_busy=%b stall=%b expected 0/0", bus.ex_busy, bus.stall);
    end
    tick();
    id_set(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // mult after reset
    tick();
    id_idle();
    for (int c = 0; c < 4; c++) begin
      sample();
      checks++;
      if (bus.ex_busy !== (c < 3)) begin
        errors++;
        $display("FAIL rst_new_mc_c%0d: ex_busy=%b expected %b", c + 1, bus.ex_busy, (c < 3));
      end
      tick();
    end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    id_idle();
    test_reset();
    test_fwd_mem_wb();
    test_load_use();
    test_store_fwd();
    test_multicycle();
    test_flush();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
